// File: rtl/posit_noncomp_pipe.sv
// Pipelined non-computational posit unit: sign injection, min/max, compare
// and classify on two posit operands of any width, with an elastic pipeline.
//
// Parameters:
//   WIDTH          posit word width (8..64)
//   NUM_PIPE_REGS  register stages between input and output (0..4)
//   TAG_WIDTH      width of the user tag carried with each operation
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   operands_i            {b, a}, each WIDTH bits
//   op_i                  0 SGNJ, 1 MINMAX, 2 CMP, 3 CLASSIFY
//   rnd_mode_i            sub-operation select
//   op_mod_i              inverts the CMP result
//   tag_i / tag_o         user tag in / out
//   in_valid_i/in_ready_o input handshake
//   flush_i               drops every in-flight operation
//   result_o              result word
//   class_mask_o          one-hot {pos, neg, zero, NaR} of operand a
//   is_class_o            result is on class_mask_o
//   out_valid_o/out_ready_i output handshake
//   busy_o                any stage holds a valid operation
//   op_count_o            output handshake counter (only with
//                         POSIT_NONCOMP_OPCNT_EN defined)
module posit_noncomp_pipe #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned NUM_PIPE_REGS = 1,
    parameter int unsigned TAG_WIDTH     = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [2*WIDTH-1:0]     operands_i,
    input  logic [1:0]             op_i,
    input  logic [2:0]             rnd_mode_i,
    input  logic                   op_mod_i,
    input  logic [TAG_WIDTH-1:0]   tag_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic                   flush_i,
    output logic [WIDTH-1:0]       result_o,
    output logic [3:0]             class_mask_o,
    output logic                   is_class_o,
    output logic [TAG_WIDTH-1:0]   tag_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic                   busy_o
`ifdef POSIT_NONCOMP_OPCNT_EN
    ,
    output logic [31:0]            op_count_o
`endif
);

    localparam logic [WIDTH-1:0] NAR = {1'b1, {(WIDTH-1){1'b0}}};

    typedef struct packed {
        logic [WIDTH-1:0]     res;
        logic [3:0]           mask;
        logic                 is_class;
        logic [TAG_WIDTH-1:0] tag;
    } stage_t;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             a_nar;
    logic             b_nar;
    logic             lt;
    logic             eq;
    logic             flip;
    logic             cmp_bit;
    stage_t           comb_d;

    assign op_a  = operands_i[WIDTH-1:0];
    assign op_b  = operands_i[2*WIDTH-1:WIDTH];
    assign a_nar = (op_a == NAR);
    assign b_nar = (op_b == NAR);
    // Posit order equals two's-complement order; NaR is the most negative.
    assign lt    = $signed(op_a) < $signed(op_b);
    assign eq    = (op_a == op_b);

    always_comb begin
        comb_d          = '0;
        comb_d.tag      = tag_i;
        flip            = 1'b0;
        cmp_bit         = 1'b0;

        if (a_nar)
            comb_d.mask = 4'b0001;
        else if (op_a == '0)
            comb_d.mask = 4'b0010;
        else if (op_a[WIDTH-1])
            comb_d.mask = 4'b0100;
        else
            comb_d.mask = 4'b1000;

        unique case (op_i)
            2'd0: begin
                case (rnd_mode_i)
                    3'd0:    flip = op_a[WIDTH-1] ^ op_b[WIDTH-1];
                    3'd1:    flip = op_a[WIDTH-1] ^ ~op_b[WIDTH-1];
                    3'd2:    flip = op_b[WIDTH-1];
                    default: flip = 1'b0;
                endcase
                // Two's-complement negate maps NaR and zero onto themselves.
                if (rnd_mode_i <= 3'd3)
                    comb_d.res = flip ? -op_a : op_a;
            end
            2'd1: begin
                if (rnd_mode_i <= 3'd1) begin
                    if (a_nar && b_nar)
                        comb_d.res = NAR;
                    else if (a_nar)
                        comb_d.res = op_b;
                    else if (b_nar)
                        comb_d.res = op_a;
                    else if (rnd_mode_i == 3'd0)
                        comb_d.res = (lt || eq) ? op_a : op_b;
                    else
                        comb_d.res = lt ? op_b : op_a;
                end
            end
            2'd2: begin
                case (rnd_mode_i)
                    3'd0:    cmp_bit = lt | eq;
                    3'd1:    cmp_bit = lt;
                    3'd2:    cmp_bit = eq;
                    default: cmp_bit = 1'b0;
                endcase
                if (rnd_mode_i <= 3'd2)
                    comb_d.res = {{(WIDTH-1){1'b0}}, cmp_bit ^ op_mod_i};
            end
            2'd3: begin
                comb_d.is_class = 1'b1;
            end
        endcase
    end

    generate
        if (NUM_PIPE_REGS == 0) begin : g_comb
            assign out_valid_o  = in_valid_i;
            assign in_ready_o   = out_ready_i;
            assign busy_o       = in_valid_i;
            assign result_o     = comb_d.res;
            assign class_mask_o = comb_d.mask;
            assign is_class_o   = comb_d.is_class;
            assign tag_o        = comb_d.tag;
        end else begin : g_pipe
            localparam int unsigned N = NUM_PIPE_REGS;

            logic [N-1:0] valid_q;
            stage_t       data_q  [N];
            logic [N-1:0] valid_d;
            stage_t       data_d  [N];
            logic [N-1:0] acc;

            for (genvar k = 0; k < N; k++) begin : g_stg
                // A stage can take data when any stage from here to the
                // output is empty or the output is being drained; this
                // collapses bubbles without a combinational ready chain.
                assign acc[k] = out_ready_i | ~(&valid_q[N-1:k]);
                if (k == 0) begin : g_first
                    assign valid_d[k] = in_valid_i & in_ready_o;
                    assign data_d[k]  = comb_d;
                end else begin : g_next
                    assign valid_d[k] = valid_q[k-1];
                    assign data_d[k]  = data_q[k-1];
                end
            end

            assign in_ready_o = acc[0] & ~flush_i;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int k = 0; k < N; k++) begin
                        valid_q[k] <= 1'b0;
                        data_q[k]  <= '0;
                    end
                end else begin
                    for (int k = 0; k < N; k++) begin
                        if (flush_i) begin
                            valid_q[k] <= 1'b0;
                        end else if (acc[k]) begin
                            valid_q[k] <= valid_d[k];
                            if (valid_d[k])
                                data_q[k] <= data_d[k];
                        end
                    end
                end
            end

            assign out_valid_o  = valid_q[N-1];
            assign busy_o       = |valid_q;
            assign result_o     = data_q[N-1].res;
            assign class_mask_o = data_q[N-1].mask;
            assign is_class_o   = data_q[N-1].is_class;
            assign tag_o        = data_q[N-1].tag;
        end
    endgenerate

`ifdef POSIT_NONCOMP_OPCNT_EN
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    assign cnt_d = (out_valid_o && out_ready_i) ? cnt_q + 32'd1 : cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign op_count_o = cnt_q;
`endif

endmodule

// File: tb/tb_posit_noncomp_pipe.sv
// Scoreboard bench for posit_noncomp_pipe (WIDTH=16, NUM_PIPE_REGS=2).
// Directed vectors with hand-computed results; a monitor checks outputs.
module tb_posit_noncomp_pipe;

    localparam int W  = 16;
    localparam int TW = 4;

    typedef struct packed {
        logic [W-1:0]  res;
        logic [3:0]    mask;
        logic          cls;
        logic [TW-1:0] tag;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [2*W-1:0] operands_i;
    logic [1:0]    op_i;
    logic [2:0]    rnd_mode_i;
    logic          op_mod_i;
    logic [TW-1:0] tag_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic          flush_i;
    logic [W-1:0]  result_o;
    logic [3:0]    class_mask_o;
    logic          is_class_o;
    logic [TW-1:0] tag_o;
    logic          out_valid_o;
    logic          out_ready_i;
    logic          busy_o;
`ifdef POSIT_NONCOMP_OPCNT_EN
    logic [31:0]   op_count_o;
`endif

    posit_noncomp_pipe #(
        .WIDTH(W), .NUM_PIPE_REGS(2), .TAG_WIDTH(TW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .operands_i(operands_i),
        .op_i(op_i), .rnd_mode_i(rnd_mode_i), .op_mod_i(op_mod_i),
        .tag_i(tag_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .flush_i(flush_i), .result_o(result_o),
        .class_mask_o(class_mask_o), .is_class_o(is_class_o),
        .tag_o(tag_o), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .busy_o(busy_o)
`ifdef POSIT_NONCOMP_OPCNT_EN
        , .op_count_o(op_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   hs     = 0;
    exp_t e;
    exp_t snap;
    exp_t cur;
    logic stall_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        n_chk++;
        if (act !== req)
            $display("FAIL %s actual=%h required=%h", name, act, req);
        else
            n_pass++;
    endtask

    // Outputs are read on the falling edge; a handshake seen here
    // completes on the following rising edge.
    always @(negedge clk_i) begin
        cur = '{res: result_o, mask: class_mask_o, cls: is_class_o,
                tag: tag_o};
        if (!rst_i) begin
            if (out_valid_o && stall_prev) begin
                n_chk++;
                if (cur !== snap)
                    $display("FAIL stall_stable actual=%h required=%h",
                             cur, snap);
                else
                    n_pass++;
            end
            if (out_valid_o && out_ready_i) begin
                hs++;
                n_chk++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_output actual=%h required=none",
                             cur);
                end else begin
                    e = sb.pop_front();
                    if (cur !== e)
                        $display("FAIL sb_out tag%0d actual=%h required=%h",
                                 e.tag, cur, e);
                    else
                        n_pass++;
                end
            end
            stall_prev = out_valid_o && !out_ready_i;
            snap = cur;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] op, input logic [2:0] rnd,
                         input logic md, input logic [TW-1:0] tg,
                         input logic [W-1:0] res, input logic [3:0] mask,
                         input logic cls);
        logic ok;
        operands_i = {b, a};
        op_i       = op;
        rnd_mode_i = rnd;
        op_mod_i   = md;
        tag_i      = tg;
        in_valid_i = 1'b1;
        sb.push_back('{res: res, mask: mask, cls: cls, tag: tg});
        for (int n = 0; n < 60; n++) begin
            @(negedge clk_i);
            ok = in_ready_o;
            @(posedge clk_i);
            #1;
            if (ok) break;
            if (n == 59) begin
                n_chk++;
                $display("FAIL accept_timeout actual=0 required=1");
            end
        end
        in_valid_i = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk_i);
        #1;
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; operands_i = '0; op_i = '0; rnd_mode_i = '0;
        op_mod_i = 1'b0; tag_i = '0; in_valid_i = 1'b0;
        flush_i = 1'b0; out_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("reset_state",
            64'({out_valid_o, busy_o, result_o, class_mask_o, is_class_o,
                 tag_o, in_ready_o}),
            64'(1));

        // Latency: MIN accepted at edge e0 appears after edge e0+1.
        @(posedge clk_i); #1 out_ready_i = 1'b1;
        issue(16'h4000, 16'hC000, 2'd1, 3'd0, 0, 4'd1,
              16'hC000, 4'b1000, 0);
        @(negedge clk_i);
        chk("lat_cycle1_invalid", 64'(out_valid_o), 64'd0);
        @(negedge clk_i);
        chk("lat_cycle2_valid", 64'(out_valid_o), 64'd1);
        @(posedge clk_i); #1;

        issue(16'h4000, 16'hC000, 2'd1, 3'd1, 0, 4'd2,
              16'h4000, 4'b1000, 0);
        issue(16'h8000, 16'h4000, 2'd1, 3'd0, 0, 4'd3,
              16'h4000, 4'b0001, 0);
        issue(16'h8000, 16'h8000, 2'd1, 3'd1, 0, 4'd4,
              16'h8000, 4'b0001, 0);
        issue(16'h7FFF, 16'h8001, 2'd1, 3'd1, 0, 4'd5,
              16'h7FFF, 4'b1000, 0);
        issue(16'h8001, 16'h8000, 2'd1, 3'd0, 0, 4'd6,
              16'h8001, 4'b0100, 0);
        issue(16'h8000, 16'h0000, 2'd2, 3'd1, 0, 4'd7,
              16'h0001, 4'b0001, 0);
        issue(16'h8000, 16'h8000, 2'd2, 3'd2, 1, 4'd8,
              16'h0000, 4'b0001, 0);
        issue(16'hC000, 16'hC000, 2'd2, 3'd0, 0, 4'd9,
              16'h0001, 4'b0100, 0);
        issue(16'h0000, 16'h0000, 2'd2, 3'd1, 0, 4'd10,
              16'h0000, 4'b0010, 0);
        issue(16'h4000, 16'hC000, 2'd0, 3'd0, 0, 4'd11,
              16'hC000, 4'b1000, 0);
        issue(16'h8000, 16'hC000, 2'd0, 3'd2, 0, 4'd12,
              16'h8000, 4'b0001, 0);
        issue(16'h1234, 16'h0000, 2'd0, 3'd1, 0, 4'd13,
              16'hEDCC, 4'b1000, 0);
        issue(16'hABCD, 16'h4000, 2'd0, 3'd3, 0, 4'd14,
              16'hABCD, 4'b0100, 0);
        issue(16'h0000, 16'h1234, 2'd3, 3'd0, 0, 4'd15,
              16'h0000, 4'b0010, 1);
        issue(16'hF000, 16'h0000, 2'd3, 3'd0, 0, 4'd0,
              16'h0000, 4'b0100, 1);
        issue(16'h0001, 16'h0002, 2'd2, 3'd3, 0, 4'd1,
              16'h0000, 4'b1000, 0);
        issue(16'h0001, 16'h0002, 2'd1, 3'd5, 0, 4'd2,
              16'h0000, 4'b1000, 0);
        issue(16'h0001, 16'h0002, 2'd0, 3'd4, 0, 4'd3,
              16'h0000, 4'b1000, 0);
        drain("drain_directed");

        // Streaming under backpressure.
        out_ready_i = 1'b0;
        fork
            for (int i = 0; i < 4; i++)
                issue(16'h1000 + 16'(i), 16'h0000, 2'd0, 3'd3, 0, TW'(i),
                      16'h1000 + 16'(i), 4'b1000, 0);
            begin
                repeat (3) @(posedge clk_i);
                @(negedge clk_i);
                chk("in_ready_full", 64'(in_ready_o), 64'd0);
                @(posedge clk_i); #1 out_ready_i = 1'b1;
            end
        join
        drain("drain_stream");

        // Flush with two operations in flight.
        out_ready_i = 1'b0;
        issue(16'h2000, 16'h0000, 2'd0, 3'd3, 0, 4'd5,
              16'h2000, 4'b1000, 0);
        issue(16'h3000, 16'h0000, 2'd0, 3'd3, 0, 4'd6,
              16'h3000, 4'b1000, 0);
        flush_i = 1'b1;
        @(negedge clk_i);
        chk("in_ready_flush", 64'(in_ready_o), 64'd0);
        @(posedge clk_i); #1 flush_i = 1'b0;
        sb.delete();
        @(negedge clk_i);
        chk("flush_cleared", 64'({busy_o, out_valid_o}), 64'd0);
        @(posedge clk_i); #1 out_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("flush_no_stale", 64'(out_valid_o), 64'd0);

        // Reset mid-stream.
        @(posedge clk_i); #1 out_ready_i = 1'b0;
        issue(16'h5000, 16'h0000, 2'd0, 3'd3, 0, 4'd7,
              16'h5000, 4'b1000, 0);
        issue(16'hC000, 16'h0000, 2'd3, 3'd0, 0, 4'd8,
              16'h0000, 4'b0100, 1);
        rst_i = 1'b1;
        #1;
        chk("reset_async",
            64'({out_valid_o, busy_o, result_o, class_mask_o, is_class_o,
                 tag_o}),
            64'd0);
        sb.delete();
        hs = 0;
        @(posedge clk_i); #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("reset_release_ready", 64'(in_ready_o), 64'd1);

        // Five handshakes after reset.
        @(posedge clk_i); #1 out_ready_i = 1'b1;
        for (int i = 0; i < 5; i++)
            issue(16'h0100 + 16'(i), 16'h0100, 2'd1, 3'd1, 0, TW'(i),
                  16'h0100 + 16'(i), 4'b1000, 0);
        drain("drain_count");
`ifdef POSIT_NONCOMP_OPCNT_EN
        chk("op_count", 64'(op_count_o), 64'd5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/posit_noncomp_pipe.md
Name: posit_noncomp_pipe

Overview:
- Parametrised, pipelined non-computational posit unit: sign injection, min/max, compare and classify on two posit operands of any width.
- Sits beside the posit arithmetic units in the PPU op-group dispatch and shares the same valid/ready, tag and flush protocol.
- Adds over the single-cycle unit: generic width with a correct NaR for every width, N bubble-collapsing pipeline stages with backpressure, flush, and an optional operation counter.

Parameters:
WIDTH, 32, posit word width in bits (8..64).
NUM_PIPE_REGS, 1, register stages between input and output (0..4); 0 = combinational path.
TAG_WIDTH, 1, width of the tag carried alongside each operation.

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  reset, asynchronous, active-high
operands_i  in  2*WIDTH  [WIDTH-1:0] = operand a, [2*WIDTH-1:WIDTH] = operand b
op_i  in  2  0 SGNJ, 1 MINMAX, 2 CMP, 3 CLASSIFY
rnd_mode_i  in  3  sub-operation select (see Behaviour)
op_mod_i  in  1  inverts CMP boolean result
tag_i  in  TAG_WIDTH  user tag
in_valid_i  in  1  input valid
in_ready_o  out  1  input accepted when high with in_valid_i
flush_i  in  1  kill all in-flight operations
result_o  out  WIDTH  result word
class_mask_o  out  4  one-hot: bit0 NaR, bit1 zero, bit2 negative, bit3 positive
is_class_o  out  1  result is on class_mask_o
tag_o  out  TAG_WIDTH  tag of the output operation
out_valid_o  out  1  output valid
out_ready_i  in  1  downstream ready
busy_o  out  1  any stage holds a valid operation

Behaviour:
- NaR = 1 followed by WIDTH-1 zeros; zero = all zeros. Posits are ordered as signed two's-complement integers, so NaR is less than every value and NaR == NaR.
- SGNJ, with flip selected by rnd_mode_i: 0 gives sa^sb, 1 gives sa^~sb, 2 gives sb, 3 gives 0 (passthrough). Result = flip ? two's-complement negate(a) : a. Negating NaR or zero returns the same word.
- MINMAX (rnd_mode_i 0 MIN, 1 MAX):
  - Both operands NaR gives NaR.
  - One operand NaR gives the other operand.
  - Otherwise the signed-integer min or max; on equality, returns a.
- CMP (rnd_mode_i 0 LE, 1 LT, 2 EQ): result = {WIDTH-1 zeros, bool ^ op_mod_i}. NaR participates as the smallest value.
- CLASSIFY:
  - class_mask_o is one-hot on operand a, priority NaR > zero > neg > pos.
  - is_class_o = 1 and result_o = 0.
  - class_mask_o is valid for every op.
- Undefined rnd_mode_i for an op: result_o = 0. No exceptions exist and no status is produced.
- Pipeline, NUM_PIPE_REGS > 0:
  - Each stage holds valid, result, class mask, is_class and tag.
  - Stage k accepts when its valid is 0 or stage k+1 (or the output) is accepting. in_ready_o = stage-0 accept.
  - No-stall latency is NUM_PIPE_REGS cycles; throughput is one op per cycle.
  - Bubbles collapse. An output held with out_valid_o=1 and out_ready_i=0 keeps every output stable.
- NUM_PIPE_REGS = 0: out_valid_o = in_valid_i, in_ready_o = out_ready_i, outputs combinational, busy_o = in_valid_i.
- Flush: on the edge where flush_i=1, all stage valids clear. in_ready_o is 0 during flush_i, and no input is accepted that cycle.
- Reset: all stage valids and data clear asynchronously. out_valid_o=0, busy_o=0, result_o=0, class_mask_o=0, is_class_o=0, tag_o=0, in_ready_o=1 after release. Reset mid-operation discards in-flight ops.
- Simultaneous accept at the input and release at the output in the same cycle is allowed, with no bubble inserted.

Optional Feature:
- Macro: POSIT_NONCOMP_OPCNT_EN.
- When defined, adds output op_count_o[31:0]:
  - Increments by one on every out_valid_o && out_ready_i handshake.
  - Wraps from 0xFFFFFFFF to 0.
  - Reset to 0 by rst_i; not affected by flush_i.
- When undefined, the port and counter are absent, with no other behavioural change.

Test Plan:
- WIDTH=16, NUM_PIPE_REGS=2, MIN of a=0x4000 and b=0xC000 → result 0xC000, out_valid_o exactly 2 cycles after accept; MAX → 0x4000.
- MINMAX with a=0x8000, b=0x4000 → 0x4000; a=b=0x8000 → 0x8000.
- CMP LT with a=0x8000, b=0x0000 → 0x0001; EQ with a=b=0x8000 and op_mod_i=1 → 0x0000; LE with a=0xC000, b=0xC000 → 0x0001.
- SGNJ rnd=0 with a=0x4000, b=0xC000 → 0xC000; rnd=2 with a=0x8000 → 0x8000; CLASSIFY a=0x0000 → class_mask_o=0010, is_class_o=1.
- Streaming backpressure: 4 back-to-back ops with tags 0..3, out_ready_i held 0 for 3 cycles then 1 → results in order, no loss or duplication, in_ready_o drops once full, outputs stable while stalled.
- Flush with 2 ops in flight → busy_o=0 and out_valid_o=0 next cycle, no stale output. Assert rst_i mid-stream → all outputs 0 immediately. With POSIT_NONCOMP_OPCNT_EN, 5 handshakes → op_count_o=5.
